// File: rtl/spi_target.sv
// SPI target endpoint: oversamples the manager's sclk/mosi/cs in the system clock domain,
// deserialises MOSI into bytes and serialises a one-entry transmit buffer onto MISO.
module spi_target #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  output logic       miso_enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       busy
);

  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       active_q, active_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_underrun_q, tx_underrun_d;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, byte_load;

  always_comb begin
    lead_edge   = active_q && !cs_sync_q[1] && (sclk_sync_q[2] == CPOL) &&
                  (sclk_sync_q[1] != CPOL);
    trail_edge  = active_q && !cs_sync_q[1] && (sclk_sync_q[2] != CPOL) &&
                  (sclk_sync_q[1] == CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    // armed_q keeps a cs that was already low when reset released from counting as a select.
    cs_fall     = armed_q && !active_q && cs_sync_q[2] && !cs_sync_q[1];
    cs_rise     = active_q && cs_sync_q[1] && !cs_sync_q[2];
    byte_load   = CPHA ? (lead_edge && (bit_cnt_q == 3'd0))
                       : (cs_fall || (trail_edge && (bit_cnt_q == 3'd0)));
  end

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], sclk};
    cs_sync_d     = {cs_sync_q[1:0], cs};
    mosi_sync_d   = {mosi_sync_q[0], mosi};
    fill_d        = {fill_q[0], 1'b1};
    armed_d       = armed_q | (fill_q[1] & cs_sync_q[1]);
    active_d      = active_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q & ~byte_load;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;

    if (cs_fall) begin
      active_d  = 1'b1;
      bit_cnt_d = 3'd0;
    end

    if (cs_rise) begin
      active_d   = 1'b0;
      bit_cnt_d  = 3'd0;
      rx_shift_d = 8'h00;
      tx_shift_d = 8'h00;
    end else begin
      if (sample_edge) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_sync_q[1]};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d  = {rx_shift_q[6:0], mosi_sync_q[1]};
          rx_valid_d = 1'b1;
        end
      end
      if (byte_load) begin
        tx_shift_d    = tx_full_q ? tx_buf_q : 8'h00;
        tx_underrun_d = ~tx_full_q;
      end else if (shift_edge) begin
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end

    // A write is only taken against the pre-load state, so a full buffer is never overwritten.
    if (tx_load && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclk_sync_q   <= {3{CPOL}};
      cs_sync_q     <= 3'b111;
      mosi_sync_q   <= 2'b00;
      fill_q        <= 2'b00;
      armed_q       <= 1'b0;
      active_q      <= 1'b0;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      tx_buf_q      <= 8'h00;
      tx_full_q     <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      active_q      <= active_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign miso        = tx_shift_q[7];
  assign miso_enable = active_q;
  assign busy        = active_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~tx_full_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: one instance per SPI mode, index m = {CPOL, CPHA}.
module tb_spi_target;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sclk_a, mosi_a, cs_a, tx_load_a;
  logic [7:0] tx_data;
  wire  [3:0] miso_a, miso_enable_a, rx_valid_a, tx_ready_a, tx_underrun_a, busy_a;
  wire  [7:0] rx_data_a [4];

  int         vec, bad, cyc, edge_cyc;
  int         rxv_cnt [4];
  int         und_cnt [4];
  int         rxv_cyc [4];
  logic [7:0] rx_last [4];
  logic [7:0] rx_prev [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_target #(.CPOL(g >= 2), .CPHA(g % 2 == 1)) u_dut (
      .clock      (clk),
      .reset_n    (reset_n),
      .sclk       (sclk_a[g]),
      .mosi       (mosi_a[g]),
      .cs         (cs_a[g]),
      .miso       (miso_a[g]),
      .miso_enable(miso_enable_a[g]),
      .rx_data    (rx_data_a[g]),
      .rx_valid   (rx_valid_a[g]),
      .tx_data    (tx_data),
      .tx_load    (tx_load_a[g]),
      .tx_ready   (tx_ready_a[g]),
      .tx_underrun(tx_underrun_a[g]),
      .busy       (busy_a[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters count high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid_a[i]) begin
        rxv_cnt[i] = rxv_cnt[i] + 1;
        rx_prev[i] = rx_last[i];
        rx_last[i] = rx_data_a[i];
        rxv_cyc[i] = cyc;
      end
      if (tx_underrun_a[i]) und_cnt[i] = und_cnt[i] + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic bit cpol(input int m);
    return m >= 2;
  endfunction

  function automatic bit cpha(input int m);
    return (m % 2) == 1;
  endfunction

  task automatic load_tx(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_data      = b;
    tx_load_a[m] = 1'b1;
    @(negedge clk);
    tx_load_a[m] = 1'b0;
  endtask

  // Manager model: select, clock nbits out of mo (MSB first), optionally deselect.
  task automatic xfer(input int m, input int nbits, input logic [15:0] mo,
                      input bit reload_en, input logic [7:0] reload_b,
                      input bit coll_en, input logic [7:0] coll_b, input bit keep_cs,
                      output logic [15:0] mi, output bit en_seen, output bit coll_rdy);
    bit pol, ph;
    pol = cpol(m);
    ph  = cpha(m);
    mi = '0;
    en_seen = 1'b0;
    coll_rdy = 1'b0;
    @(negedge clk);
    cs_a[m] = 1'b0;
    if (!ph) mosi_a[m] = mo[15];
    if (coll_en) begin
      @(negedge clk);
      @(negedge clk);
      tx_data      = coll_b;
      tx_load_a[m] = 1'b1;
      @(negedge clk);
      tx_load_a[m] = 1'b0;
      coll_rdy     = tx_ready_a[m];
    end
    repeat (H) @(negedge clk);
    en_seen = miso_enable_a[m] && busy_a[m];
    for (int k = 0; k < nbits; k++) begin
      if (reload_en && k == 1) load_tx(m, reload_b);
      if (!ph) begin
        mi[15-k]  = miso_a[m];
        sclk_a[m] = !pol;
        if (k % 8 == 7) edge_cyc = cyc;
        repeat (H) @(negedge clk);
        sclk_a[m] = pol;
        if (k + 1 < nbits) mosi_a[m] = mo[14-k];
        repeat (H) @(negedge clk);
      end else begin
        sclk_a[m] = !pol;
        mosi_a[m] = mo[15-k];
        repeat (H) @(negedge clk);
        mi[15-k]  = miso_a[m];
        sclk_a[m] = pol;
        if (k % 8 == 7) edge_cyc = cyc;
        repeat (H) @(negedge clk);
      end
    end
    if (!keep_cs) begin
      cs_a[m]   = 1'b1;
      mosi_a[m] = 1'b0;
    end
    repeat (H) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      vec++; if (miso_a[m] !== 1'b0) begin bad++; $display("FAIL reset_miso[%0d]: got %b expected 0", m, miso_a[m]); end
      vec++; if (miso_enable_a[m] !== 1'b0 || busy_a[m] !== 1'b0) begin bad++; $display("FAIL reset_enable[%0d]: got %b/%b expected 0/0", m, miso_enable_a[m], busy_a[m]); end
      vec++; if (rx_data_a[m] !== 8'h00) begin bad++; $display("FAIL reset_rx_data[%0d]: got %h expected 00", m, rx_data_a[m]); end
      vec++; if (rx_valid_a[m] !== 1'b0 || tx_underrun_a[m] !== 1'b0) begin bad++; $display("FAIL reset_pulses[%0d]: got %b/%b expected 0/0", m, rx_valid_a[m], tx_underrun_a[m]); end
      vec++; if (tx_ready_a[m] !== 1'b1) begin bad++; $display("FAIL reset_tx_ready[%0d]: got %b expected 1", m, tx_ready_a[m]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_collision;
    logic [15:0] mi; bit en, cr; int u0;
    load_tx(0, 8'hA5);
    vec++; if (tx_ready_a[0] !== 1'b0) begin bad++; $display("FAIL coll_preload_ready: got %b expected 0", tx_ready_a[0]); end
    u0 = und_cnt[0];
    xfer(0, 8, 16'h0F00, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, mi, en, cr);
    vec++; if (cr !== 1'b1) begin bad++; $display("FAIL coll_ready: got %b expected 1", cr); end
    vec++; if (mi[15:8] !== 8'hA5) begin bad++; $display("FAIL coll_miso: got %h expected a5", mi[15:8]); end
    vec++; if (rx_last[0] !== 8'h0F) begin bad++; $display("FAIL coll_rx: got %h expected 0f", rx_last[0]); end
    vec++; if (und_cnt[0] - u0 !== 1) begin bad++; $display("FAIL coll_underruns: got %0d expected 1", und_cnt[0] - u0); end
  endtask

  task automatic test_single;
    logic [15:0] mi; bit en, cr; int r0, u0;
    load_tx(0, 8'hA5);
    vec++; if (tx_ready_a[0] !== 1'b0) begin bad++; $display("FAIL single_preload_ready: got %b expected 0", tx_ready_a[0]); end
    r0 = rxv_cnt[0];
    u0 = und_cnt[0];
    xfer(0, 8, 16'h3C00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mi, en, cr);
    vec++; if (en !== 1'b1) begin bad++; $display("FAIL single_enable: got %b expected 1", en); end
    vec++; if (mi[15:8] !== 8'hA5) begin bad++; $display("FAIL single_miso: got %h expected a5", mi[15:8]); end
    vec++; if (rxv_cnt[0] - r0 !== 1) begin bad++; $display("FAIL single_rx_valid_cycles: got %0d expected 1", rxv_cnt[0] - r0); end
    vec++; if (rx_last[0] !== 8'h3C || rx_data_a[0] !== 8'h3C) begin bad++; $display("FAIL single_rx_data: got %h/%h expected 3c", rx_last[0], rx_data_a[0]); end
    vec++; if (rxv_cyc[0] - edge_cyc !== 3) begin bad++; $display("FAIL single_rx_latency: got %0d expected 3", rxv_cyc[0] - edge_cyc); end
    vec++; if (tx_ready_a[0] !== 1'b1) begin bad++; $display("FAIL single_tx_ready: got %b expected 1", tx_ready_a[0]); end
    vec++; if (und_cnt[0] - u0 !== 1) begin bad++; $display("FAIL single_underruns: got %0d expected 1", und_cnt[0] - u0); end
    vec++; if (miso_enable_a[0] !== 1'b0 || miso_a[0] !== 1'b0) begin bad++; $display("FAIL single_idle: got %b/%b expected 0/0", miso_enable_a[0], miso_a[0]); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] mi; bit en, cr; int r0, u0;
    load_tx(0, 8'h5A);
    r0 = rxv_cnt[0];
    u0 = und_cnt[0];
    xfer(0, 16, 16'h0180, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, mi, en, cr);
    vec++; if (mi !== 16'h5AC3) begin bad++; $display("FAIL b2b_miso: got %h expected 5ac3", mi); end
    vec++; if (rxv_cnt[0] - r0 !== 2) begin bad++; $display("FAIL b2b_rx_valid_cycles: got %0d expected 2", rxv_cnt[0] - r0); end
    vec++; if (rx_prev[0] !== 8'h01 || rx_last[0] !== 8'h80) begin bad++; $display("FAIL b2b_rx_data: got %h,%h expected 01,80", rx_prev[0], rx_last[0]); end
    vec++; if (und_cnt[0] - u0 !== 1) begin bad++; $display("FAIL b2b_underruns: got %0d expected 1", und_cnt[0] - u0); end
  endtask

  task automatic test_underrun;
    logic [15:0] mi; bit en, cr; int r0, u0;
    vec++; if (tx_ready_a[0] !== 1'b1) begin bad++; $display("FAIL under_empty: got %b expected 1", tx_ready_a[0]); end
    r0 = rxv_cnt[0];
    u0 = und_cnt[0];
    xfer(0, 8, 16'h4200, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mi, en, cr);
    vec++; if (mi[15:8] !== 8'h00) begin bad++; $display("FAIL under_miso: got %h expected 00", mi[15:8]); end
    vec++; if (und_cnt[0] - u0 !== 2) begin bad++; $display("FAIL under_pulses: got %0d expected 2", und_cnt[0] - u0); end
    vec++; if (rxv_cnt[0] - r0 !== 1 || rx_last[0] !== 8'h42) begin bad++; $display("FAIL under_rx: got %0d/%h expected 1/42", rxv_cnt[0] - r0, rx_last[0]); end
  endtask

  task automatic test_abort;
    logic [15:0] mi; bit en, cr; int r0;
    r0 = rxv_cnt[0];
    xfer(0, 5, 16'hB800, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mi, en, cr);
    vec++; if (rxv_cnt[0] - r0 !== 0) begin bad++; $display("FAIL abort_partial: got %0d expected 0", rxv_cnt[0] - r0); end
    vec++; if (miso_enable_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin bad++; $display("FAIL abort_gap_enable: got %b/%b expected 0/0", miso_enable_a[0], busy_a[0]); end
    vec++; if (miso_a[0] !== 1'b0) begin bad++; $display("FAIL abort_gap_miso: got %b expected 0", miso_a[0]); end
    xfer(0, 8, 16'hFF00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mi, en, cr);
    vec++; if (rxv_cnt[0] - r0 !== 1 || rx_last[0] !== 8'hFF) begin bad++; $display("FAIL abort_next: got %0d/%h expected 1/ff", rxv_cnt[0] - r0, rx_last[0]); end
  endtask

  task automatic test_modes;
    logic [15:0] mi; bit en, cr; int r0, u0;
    for (int m = 0; m < 4; m++) begin
      load_tx(m, 8'h96);
      r0 = rxv_cnt[m];
      u0 = und_cnt[m];
      xfer(m, 8, 16'h6900, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mi, en, cr);
      vec++; if (mi[15:8] !== 8'h96) begin bad++; $display("FAIL mode%0d_miso: got %h expected 96", m, mi[15:8]); end
      vec++; if (rxv_cnt[m] - r0 !== 1 || rx_data_a[m] !== 8'h69) begin bad++; $display("FAIL mode%0d_rx: got %0d/%h expected 1/69", m, rxv_cnt[m] - r0, rx_data_a[m]); end
      vec++; if (und_cnt[m] - u0 !== (cpha(m) ? 0 : 1)) begin bad++; $display("FAIL mode%0d_underruns: got %0d expected %0d", m, und_cnt[m] - u0, cpha(m) ? 0 : 1); end
      vec++; if (rxv_cyc[m] - edge_cyc !== 3) begin bad++; $display("FAIL mode%0d_rx_latency: got %0d expected 3", m, rxv_cyc[m] - edge_cyc); end
    end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] mi; bit en, cr; int r0;
    xfer(1, 4, 16'h5500, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, mi, en, cr);
    load_tx(1, 8'h22);
    vec++; if (busy_a[1] !== 1'b1 || tx_ready_a[1] !== 1'b0) begin bad++; $display("FAIL mid_pre: got %b/%b expected 1/0", busy_a[1], tx_ready_a[1]); end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (miso_a[1] !== 1'b0 || miso_enable_a[1] !== 1'b0 || busy_a[1] !== 1'b0) begin bad++; $display("FAIL mid_reset_pins: got %b%b%b expected 000", miso_a[1], miso_enable_a[1], busy_a[1]); end
    vec++; if (rx_data_a[1] !== 8'h00 || rx_valid_a[1] !== 1'b0 || tx_underrun_a[1] !== 1'b0) begin bad++; $display("FAIL mid_reset_rx: got %h/%b/%b expected 00/0/0", rx_data_a[1], rx_valid_a[1], tx_underrun_a[1]); end
    vec++; if (tx_ready_a[1] !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b expected 1", tx_ready_a[1]); end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    vec++; if (miso_enable_a[1] !== 1'b0) begin bad++; $display("FAIL mid_low_cs_select: got %b expected 0", miso_enable_a[1]); end
    cs_a[1] = 1'b1;
    repeat (10) @(negedge clk);
    r0 = rxv_cnt[1];
    xfer(1, 8, 16'hC300, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, mi, en, cr);
    vec++; if (mi[15:8] !== 8'h00) begin bad++; $display("FAIL mid_after_miso: got %h expected 00", mi[15:8]); end
    vec++; if (rxv_cnt[1] - r0 !== 1 || rx_last[1] !== 8'hC3) begin bad++; $display("FAIL mid_after_rx: got %0d/%h expected 1/c3", rxv_cnt[1] - r0, rx_last[1]); end
  endtask

  initial begin
    vec = 0;
    bad = 0;
    cyc = 0;
    edge_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      rxv_cnt[i] = 0;
      und_cnt[i] = 0;
      rxv_cyc[i] = 0;
      rx_last[i] = 8'h00;
      rx_prev[i] = 8'h00;
      sclk_a[i]  = cpol(i);
    end
    mosi_a    = 4'b0000;
    cs_a      = 4'b1111;
    tx_load_a = 4'b0000;
    tx_data   = 8'h00;
    reset_n   = 1'b0;
    test_reset();
    test_collision();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_modes();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
